// File: rtl/divider_fp.sv
// Iterative IEEE-754 single-precision divider, Y = A / B, one quotient bit per cycle.
// Shares the start/busy/ready handshake with the FP multiplier.
module divider_fp #(
  parameter logic [31:0] NAN_PATTERN = 32'h7F80_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        ready,
  output logic        busy,
  output logic [31:0] Y
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StAlign,
    StDivide,
    StRound,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic [7:0]         exp_a_q, exp_a_d;
  logic [7:0]         exp_b_q, exp_b_d;
  logic [23:0]        mant_a_q, mant_a_d;
  logic [23:0]        mant_b_q, mant_b_d;
  logic signed [9:0]  e_q, e_d;
  logic [25:0]        rem_q, rem_d;
  logic [23:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic [31:0]        y_q, y_d;

  // Operand classification (exponent 0 is zero: denormals are flushed)
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign a_zero = (exp_a_q == 8'd0);
  assign b_zero = (exp_b_q == 8'd0);
  assign a_inf  = (exp_a_q == 8'hFF) && (mant_a_q[22:0] == 23'd0);
  assign b_inf  = (exp_b_q == 8'hFF) && (mant_b_q[22:0] == 23'd0);
  assign a_nan  = (exp_a_q == 8'hFF) && (mant_a_q[22:0] != 23'd0);
  assign b_nan  = (exp_b_q == 8'hFF) && (mant_b_q[22:0] != 23'd0);

  // Restoring divide step
  logic        rem_ge;
  logic [25:0] rem_sub;
  assign rem_ge  = (rem_q >= {2'b00, mant_b_q});
  assign rem_sub = rem_ge ? (rem_q - {2'b00, mant_b_q}) : rem_q;

  // quo_q holds q[23:0]; q[24] is always 1 and is shifted out.
  logic              round_up;
  logic [23:0]       frac_sum;
  logic signed [9:0] e_r;
  logic [31:0]       round_res;
  assign round_up = quo_q[0] & ((|rem_q) | quo_q[1]);
  assign frac_sum = {1'b0, quo_q[23:1]} + {23'd0, round_up};
  assign e_r      = frac_sum[23] ? (e_q + 10'sd1) : e_q;

  always_comb begin
    if (e_r >= 10'sd255) begin
      round_res = {sign_q, 8'hFF, 23'd0};
    end else if (e_r <= 10'sd0) begin
      round_res = {sign_q, 31'd0};
    end else begin
      round_res = {sign_q, e_r[7:0], frac_sum[22:0]};
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_a_d  = exp_a_q;
    exp_b_d  = exp_b_q;
    mant_a_d = mant_a_q;
    mant_b_d = mant_b_q;
    e_d      = e_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    y_d      = y_q;

    unique case (state_q)
      StIdle: begin
        ready_d = 1'b0;
        if (start) begin
          sign_d   = A[31] ^ B[31];
          exp_a_d  = A[30:23];
          exp_b_d  = B[30:23];
          mant_a_d = {1'b1, A[22:0]};
          mant_b_d = {1'b1, B[22:0]};
          busy_d   = 1'b1;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        state_d = StDone;
        if (a_nan || b_nan) begin
          res_d = NAN_PATTERN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
          res_d = NAN_PATTERN;
        end else if (a_zero || b_inf) begin
          res_d = {sign_q, 31'd0};
        end else if (a_inf || b_zero) begin
          res_d = {sign_q, 8'hFF, 23'd0};
        end else begin
          e_d     = $signed({2'b00, exp_a_q}) - $signed({2'b00, exp_b_q}) + 10'sd127;
          state_d = StAlign;
        end
      end
      StAlign: begin
        // Pre-shift so the quotient always lands in [1, 2)
        if (mant_a_q < mant_b_q) begin
          rem_d = {1'b0, mant_a_q, 1'b0};
          e_d   = e_q - 10'sd1;
        end else begin
          rem_d = {2'b00, mant_a_q};
        end
        quo_d   = 24'd0;
        cnt_d   = 5'd24;
        state_d = StDivide;
      end
      StDivide: begin
        quo_d = {quo_q[22:0], rem_ge};
        rem_d = rem_sub << 1;
        if (cnt_q == 5'd0) begin
          state_d = StRound;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StRound: begin
        res_d   = round_res;
        state_d = StDone;
      end
      StDone: begin
        y_d     = res_q;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_a_q  <= 8'd0;
      exp_b_q  <= 8'd0;
      mant_a_q <= 24'd0;
      mant_b_q <= 24'd0;
      e_q      <= 10'sd0;
      rem_q    <= 26'd0;
      quo_q    <= 24'd0;
      cnt_q    <= 5'd0;
      res_q    <= 32'd0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      y_q      <= 32'd0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_a_q  <= exp_a_d;
      exp_b_q  <= exp_b_d;
      mant_a_q <= mant_a_d;
      mant_b_q <= mant_b_d;
      e_q      <= e_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      y_q      <= y_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign Y     = y_q;

endmodule

// File: tb/tb_divider_fp.sv
// Self-checking bench for divider_fp: directed specials, range limits, handshake, reset,
// and random operands against an integer long-division reference model.
module tb_divider_fp;

  localparam logic [31:0] NAN = 32'h7F80_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        ready;
  logic        busy;
  logic [31:0] Y;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  divider_fp dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .ready (ready),
    .busy  (busy),
    .Y     (Y)
  );

  // Reference: exact integer quotient of the significands, then round-to-nearest-even.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          output int lat);
    logic   s;
    int     ea, eb, e;
    longint fa, fb, ma, mb, num, q, r, mant;
    bit     up;
    logic [7:0]  e8;
    logic [22:0] f23;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    fa  = longint'(a[22:0]);
    fb  = longint'(b[22:0]);
    lat = 2;
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return NAN;
    if ((ea == 0 && eb == 0) || (ea == 255 && eb == 255)) return NAN;
    if (ea == 0 || eb == 255) return {s, 31'd0};
    if (ea == 255 || eb == 0) return {s, 8'hFF, 23'd0};
    lat = 29;
    ma  = fa + 64'h80_0000;
    mb  = fb + 64'h80_0000;
    e   = ea - eb + 127;
    if (ma < mb) begin
      num = ma << 25;
      e   = e - 1;
    end else begin
      num = ma << 24;
    end
    q    = num / mb;
    r    = num % mb;
    mant = q / 2;
    up   = (q % 2 == 1) && (r != 0 || mant % 2 == 1);
    if (up) mant = mant + 1;
    if (mant == 64'h100_0000) begin
      mant = 64'h80_0000;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    e8  = e[7:0];
    f23 = mant[22:0];
    return {s, e8, f23};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One divide; optionally pulses start with other operands at wait cycle pulse_at.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag,
                        input int pulse_at);
    logic [31:0] expy;
    int          lat, cyc, busy_n;
    expy  = ref_div(a, b, lat);
    start = 1'b1;
    A     = a;
    B     = b;
    @(posedge clk); #1;
    start  = 1'b0;
    A      = $urandom;
    B      = $urandom;
    cyc    = 0;
    busy_n = 0;
    while (ready !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) busy_n++;
      if (cyc == pulse_at) begin
        start = 1'b1;
        A     = 32'h3F80_0000;
        B     = 32'h4040_0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    chk({tag, " Y"}, Y, expy);
    chk({tag, " busy cycles"}, 32'(busy_n), 32'(lat));
    chk({tag, " busy at ready"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " ready pulse width"}, {31'd0, ready}, 32'd0);
  endtask

  task automatic quiet_window(input string tag, input int n);
    int rdy_n, busy_n;
    rdy_n  = 0;
    busy_n = 0;
    for (int i = 0; i < n; i++) begin
      if (ready === 1'b1) rdy_n++;
      if (busy === 1'b1) busy_n++;
      @(posedge clk); #1;
    end
    chk({tag, " stray ready"}, 32'(rdy_n), 32'd0);
    chk({tag, " stray busy"}, 32'(busy_n), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] al[3];
    logic [31:0] bl[3];
    logic [31:0] ra, rb;
    int          pc[3];
    logic [31:0] py[3];
    int          np, cyc, lat;

    rst   = 1'b1;
    start = 1'b0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset Y", Y, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'h40C0_0000, 32'h4000_0000, "6/2", -1);
    chk("6/2 literal", Y, 32'h4040_0000);
    run_op(32'h3F80_0000, 32'h4040_0000, "1/3", -1);
    chk("1/3 literal", Y, 32'h3EAA_AAAB);

    run_op(32'h3F80_0000, 32'h0000_0000, "1/0", -1);
    run_op(32'hBF80_0000, 32'h0000_0000, "-1/0", -1);
    run_op(32'h0000_0000, 32'h0000_0000, "0/0", -1);
    run_op(32'h7F80_0000, 32'hFF80_0000, "inf/-inf", -1);
    run_op(32'h4000_0000, 32'h7F80_0000, "2/inf", -1);
    run_op(32'h7FC0_0000, 32'h3F80_0000, "nan/1", -1);
    run_op(32'h7F7F_FFFF, 32'h0080_0000, "overflow", -1);
    chk("overflow literal", Y, 32'h7F80_0000);
    run_op(32'h0080_0000, 32'h4000_0000, "flush", -1);
    run_op(32'h0000_0001, 32'h3F80_0000, "denormal", -1);
    run_op(32'hC0A0_0000, 32'h3F40_0000, "-5/0.75", -1);

    // Second start mid-divide must be ignored
    run_op(32'h40C0_0000, 32'h4000_0000, "midstart", 10);
    quiet_window("midstart", 40);

    // start held high: operands advanced at each ready so each op is distinct
    al[0] = 32'h40C0_0000; bl[0] = 32'h4000_0000;
    al[1] = 32'h3F80_0000; bl[1] = 32'h4040_0000;
    al[2] = 32'hC1200000;  bl[2] = 32'h4080_0000;
    for (int i = 0; i < 3; i++) begin
      pc[i] = 0;
      py[i] = 32'd0;
    end
    np    = 0;
    start = 1'b1;
    A     = al[0];
    B     = bl[0];
    @(posedge clk); #1;
    cyc = 0;
    while (np < 3 && cyc < 200) begin
      if (ready === 1'b1) begin
        pc[np] = cyc;
        py[np] = Y;
        np++;
        if (np < 3) begin
          A = al[np];
          B = bl[np];
        end else begin
          start = 1'b0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("b2b pulse count", 32'(np), 32'd3);
    chk("b2b first latency", 32'(pc[0]), 32'd29);
    chk("b2b gap 1", 32'(pc[1] - pc[0] - 1), 32'd29);
    chk("b2b gap 2", 32'(pc[2] - pc[1] - 1), 32'd29);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b Y%0d", i), py[i], ref_div(al[i], bl[i], lat));
    end
    quiet_window("b2b tail", 35);

    // Asynchronous reset in the middle of a divide
    run_op(32'h40C0_0000, 32'h4000_0000, "pre-reset", -1);
    start = 1'b1;
    A     = 32'h3F80_0000;
    B     = 32'h4040_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy before reset", {31'd0, busy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async reset ready", {31'd0, ready}, 32'd0);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset Y", Y, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    quiet_window("post-reset", 40);
    run_op(32'h3F80_0000, 32'h4040_0000, "after reset", -1);

    // Random normal operands in a moderate exponent range
    for (int i = 0; i < 30; i++) begin
      ra        = $urandom;
      rb        = $urandom;
      ra[30:23] = 8'($urandom_range(190, 64));
      rb[30:23] = 8'($urandom_range(190, 64));
      run_op(ra, rb, $sformatf("rand%0d", i), -1);
    end
    // Fully random encodings reach overflow, flush and specials
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, $sformatf("wide%0d", i), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
